// File: rtl/regfile_debug_port_if.sv
// Register-file access bus, dump stream and load stream seen by the debug port.
// "master" is the debug port side; "slave" is the regfile / stream partner side.
interface regfile_debug_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  // Register file ports (two combinational reads, one clocked write)
  logic [ADDR_W-1:0] rf_ra1;
  logic [ADDR_W-1:0] rf_ra2;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa3;
  logic [DATA_W-1:0] rf_wd3;

  // Dump stream (address/value beats out)
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  // Load stream (words in)
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;

  modport master (
    output rf_ra1, rf_ra2,
    input  rf_rd1, rf_rd2,
    output rf_we, rf_wa3, rf_wd3,
    output dump_valid, dump_addr, dump_data,
    input  dump_ready,
    input  load_valid, load_data,
    output load_ready
  );

  modport slave (
    input  rf_ra1, rf_ra2,
    output rf_rd1, rf_rd2,
    input  rf_we, rf_wa3, rf_wd3,
    input  dump_valid, dump_addr, dump_data,
    output dump_ready,
    output load_valid, load_data,
    input  load_ready
  );
endinterface

// File: rtl/regfile_debug_port.sv
// Debug-side initiator on the register file while the core is halted.
// Dump: reads R0..LAST_REG two at a time and streams (addr, value) beats.
// Load: writes a word stream sequentially into R0..LAST_REG.
// The register above LAST_REG (the PC alias) is read in the last pair but
// never emitted, and is never written. LAST_REG must be even.
module regfile_debug_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int LAST_REG = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  output logic                 busy,
  output logic                 done,
  regfile_debug_port_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMP_RD,
    S_SEND0,
    S_SEND1,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   buf1_q, buf1_d;

  // State, index and read-pair buffers; synchronous reset returns to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // Next-state and all outputs; reset forces every output low in its own cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    busy           = 1'b0;
    done           = 1'b0;
    bus.rf_ra1     = '0;
    bus.rf_ra2     = '0;
    bus.rf_we      = 1'b0;
    bus.rf_wa3     = '0;
    bus.rf_wd3     = '0;
    bus.dump_valid = 1'b0;
    bus.dump_addr  = '0;
    bus.dump_data  = '0;
    bus.load_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = mode ? S_LOAD : S_DUMP_RD;
        end
      end

      S_DUMP_RD: begin
        busy       = 1'b1;
        bus.rf_ra1 = idx_q;
        bus.rf_ra2 = idx_q + ONE;
        buf0_d     = bus.rf_rd1;
        buf1_d     = bus.rf_rd2;
        state_d    = S_SEND0;
      end

      S_SEND0: begin
        busy           = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_addr  = idx_q;
        bus.dump_data  = buf0_q;
        if (bus.dump_ready) begin
          // The odd partner of the last even register is the PC alias: skip it.
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_SEND1;
        end
      end

      S_SEND1: begin
        busy           = 1'b1;
        bus.dump_valid = 1'b1;
        bus.dump_addr  = idx_q + ONE;
        bus.dump_data  = buf1_q;
        if (bus.dump_ready) begin
          idx_d   = idx_q + TWO;
          state_d = S_DUMP_RD;
        end
      end

      S_LOAD: begin
        busy           = 1'b1;
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          // Write goes out combinationally so it lands on this same edge.
          bus.rf_we  = 1'b1;
          bus.rf_wa3 = idx_q;
          bus.rf_wd3 = bus.load_data;
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + ONE;
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      busy           = 1'b0;
      done           = 1'b0;
      bus.rf_ra1     = '0;
      bus.rf_ra2     = '0;
      bus.rf_we      = 1'b0;
      bus.rf_wa3     = '0;
      bus.rf_wd3     = '0;
      bus.dump_valid = 1'b0;
      bus.dump_addr  = '0;
      bus.dump_data  = '0;
      bus.load_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: a behavioural 16-entry register file,
// scoreboard queues for expected dump beats and expected regfile writes.
// Inputs are driven at the falling edge, outputs sampled 1 time unit later.
module tb_regfile_debug_port;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic mode;
  logic busy;
  logic done;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t exp_q[$];
  beat_t wr_q[$];

  regfile_debug_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_debug_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAST_REG(14)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational reads, write on rising edge,
  // plus a bench-only bulk preload (R0..R14 = base+n, R15 = pc).
  logic [DATA_W-1:0] rf_mem [16];
  logic              pl_en;
  logic [DATA_W-1:0] pl_base;
  logic [DATA_W-1:0] pl_pc;

  assign bus.rf_rd1 = rf_mem[bus.rf_ra1];
  assign bus.rf_rd2 = rf_mem[bus.rf_ra2];

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 15; i++) rf_mem[i] <= pl_base + DATA_W'(i);
      rf_mem[15] <= pl_pc;
    end else if (bus.rf_we) begin
      rf_mem[bus.rf_wa3] <= bus.rf_wd3;
    end
  end

  task automatic preload(input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] pc);
    @(negedge clk);
    pl_en = 1'b1; pl_base = base; pl_pc = pc;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic push_dump_exp(input logic [DATA_W-1:0] base);
    for (int i = 0; i < 15; i++) exp_q.push_back('{addr: ADDR_W'(i), data: base + DATA_W'(i)});
  endtask

  // Starts a dump and follows it to done. bp=1 applies ready pattern 1,0,0,...
  task automatic run_dump(input bit bp, output int first_cyc, output int busy_cyc,
                          output int n_beats);
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    bit                prev_stall;
    bit                fin;
    beat_t             e;
    first_cyc = -1; busy_cyc = 0; n_beats = 0;
    prev_stall = 1'b0; fin = 1'b0; prev_addr = '0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; bus.dump_ready = 1'b1;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.dump_ready = bp ? (c % 3 == 2) : 1'b1;
      #1;
      if (busy && !done) busy_cyc++;
      if (bus.dump_valid) begin
        if (first_cyc < 0) first_cyc = c;
        if (prev_stall) begin
          n_tests++;
          if (bus.dump_addr !== prev_addr || bus.dump_data !== prev_data) begin
            n_fail++;
            $display("FAIL dump_hold: got %h/%h want %h/%h", bus.dump_addr, bus.dump_data,
                     prev_addr, prev_data);
          end
        end
        if (bus.dump_ready) begin
          n_beats++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL dump_extra: got beat %h/%h want none", bus.dump_addr, bus.dump_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.dump_addr !== e.addr || bus.dump_data !== e.data) begin
              n_fail++;
              $display("FAIL dump_beat: got %h/%h want %h/%h", bus.dump_addr, bus.dump_data,
                       e.addr, e.data);
            end
          end
        end
        prev_stall = !bus.dump_ready;
        prev_addr  = bus.dump_addr;
        prev_data  = bus.dump_data;
      end else begin
        if (prev_stall) begin
          n_tests++; n_fail++;
          $display("FAIL dump_drop: got valid=0 want valid=1 while stalled");
        end
        prev_stall = 1'b0;
      end
      if (bus.rf_we !== 1'b0) begin
        n_tests++; n_fail++;
        $display("FAIL dump_we: got rf_we=%b want 0", bus.rf_we);
      end
      if (done) fin = 1'b1;
    end
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL dump_timeout: got no done want done");
    end
  endtask

  // Starts a load of 15 words base+n. gap_at>=0 inserts 3 idle cycles before
  // that word; poke_start pulses start during the gap.
  task automatic run_load(input logic [DATA_W-1:0] base, input int gap_at, input bit poke_start,
                          output int n_wr, output int first_wr, output bit consecutive);
    int    w, gap_left, last_wr;
    bit    fin, gap_used, in_gap;
    beat_t e;
    for (int i = 0; i < 15; i++) wr_q.push_back('{addr: ADDR_W'(i), data: base + DATA_W'(i)});
    w = 0; gap_left = 0; last_wr = -1; fin = 1'b0; gap_used = 1'b0;
    n_wr = 0; first_wr = -1; consecutive = 1'b1;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; bus.load_valid = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0; mode = 1'b0;
      if (gap_at >= 0 && w == gap_at && !gap_used) begin
        gap_left = 3; gap_used = 1'b1;
      end
      if (gap_left > 0) begin
        in_gap = 1'b1;
        gap_left--;
        bus.load_valid = 1'b0;
        if (poke_start) begin start = 1'b1; mode = 1'b0; end
      end else begin
        in_gap = 1'b0;
        bus.load_valid = (w < 15);
        bus.load_data  = base + DATA_W'(w);
      end
      #1;
      if (in_gap) begin
        n_tests++;
        if (bus.rf_we !== 1'b0) begin
          n_fail++;
          $display("FAIL load_gap_we: got rf_we=%b want 0", bus.rf_we);
        end
      end
      if (bus.rf_we) begin
        n_tests++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_extra: got write %h<=%h want none", bus.rf_wa3, bus.rf_wd3);
        end else begin
          e = wr_q.pop_front();
          if (bus.rf_wa3 !== e.addr || bus.rf_wd3 !== e.data) begin
            n_fail++;
            $display("FAIL load_write: got %h<=%h want %h<=%h", bus.rf_wa3, bus.rf_wd3,
                     e.addr, e.data);
          end
        end
        if (last_wr >= 0 && last_wr != c - 1) consecutive = 1'b0;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        n_wr++;
      end
      if (bus.load_valid && bus.load_ready) w++;
      if (done) fin = 1'b1;
    end
    bus.load_valid = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL load_timeout: got no done want done");
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({busy, done, bus.dump_valid, bus.load_ready, bus.rf_we} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl: got %b want 00000",
                 {busy, done, bus.dump_valid, bus.load_ready, bus.rf_we});
      end
      n_tests++;
      if ({bus.rf_ra1, bus.rf_ra2, bus.rf_wa3, bus.rf_wd3, bus.dump_addr, bus.dump_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_bus: got ra1=%h ra2=%h wa3=%h wd3=%h da=%h dd=%h want all 0",
                 bus.rf_ra1, bus.rf_ra2, bus.rf_wa3, bus.rf_wd3, bus.dump_addr, bus.dump_data);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_dump_full;
    int first_cyc, busy_cyc, n_beats;
    preload(16'h1000, 16'd4);
    push_dump_exp(16'h1000);
    run_dump(1'b0, first_cyc, busy_cyc, n_beats);
    n_tests++;
    if (first_cyc != 2) begin
      n_fail++; $display("FAIL dump_first_latency: got %0d want 2", first_cyc);
    end
    // 8 read cycles + 15 send cycles between start and done
    n_tests++;
    if (busy_cyc != 23) begin
      n_fail++; $display("FAIL dump_cycles: got %0d want 23", busy_cyc);
    end
    n_tests++;
    if (n_beats != 15 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL dump_count: got %0d beats (%0d left) want 15 (0)", n_beats, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int first_cyc, busy_cyc, n_beats;
    preload(16'h2000, 16'd4);
    push_dump_exp(16'h2000);
    run_dump(1'b1, first_cyc, busy_cyc, n_beats);
    n_tests++;
    if (n_beats != 15 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d beats (%0d left) want 15 (0)", n_beats, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_load_full;
    int n_wr, first_wr, first_cyc, busy_cyc, n_beats;
    bit consec;
    preload(16'h5555, 16'd4);
    run_load(16'hA000, -1, 1'b0, n_wr, first_wr, consec);
    n_tests++;
    if (n_wr != 15 || first_wr != 1 || !consec) begin
      n_fail++;
      $display("FAIL load_full_we: got %0d writes from cycle %0d consecutive=%0d want 15 from 1 consecutive=1",
               n_wr, first_wr, consec);
    end
    n_tests++;
    if (rf_mem[15] !== 16'd4) begin
      n_fail++; $display("FAIL load_pc: got R15=%h want 0004", rf_mem[15]);
    end
    wr_q.delete();
    push_dump_exp(16'hA000);
    run_dump(1'b0, first_cyc, busy_cyc, n_beats);
    n_tests++;
    if (n_beats != 15 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL load_readback: got %0d beats want 15", n_beats);
    end
    exp_q.delete();
  endtask

  task automatic test_load_gaps;
    int n_wr, first_wr;
    bit consec;
    preload(16'h7777, 16'd4);
    run_load(16'hB000, 6, 1'b1, n_wr, first_wr, consec);
    n_tests++;
    if (n_wr != 15 || wr_q.size() != 0) begin
      n_fail++; $display("FAIL gap_count: got %0d writes want 15", n_wr);
    end
    n_tests++;
    if (rf_mem[6] !== 16'hB006 || rf_mem[15] !== 16'd4) begin
      n_fail++; $display("FAIL gap_mem: got R6=%h R15=%h want b006 0004", rf_mem[6], rf_mem[15]);
    end
    wr_q.delete();
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL gap_poke: got busy=%b want 0 after done", busy);
    end
  endtask

  task automatic test_dump_reset;
    int n_done;
    preload(16'd100, 16'd115);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; bus.dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.dump_valid !== 1'b1 || bus.dump_addr !== 4'd0 || bus.dump_data !== 16'd100) begin
      n_fail++;
      $display("FAIL rst_dump_first: got v=%b %h/%h want 1 0/0064", bus.dump_valid, bus.dump_addr, bus.dump_data);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, bus.dump_valid, bus.rf_we} !== 4'b0) begin
      n_fail++; $display("FAIL rst_dump_same: got %b want 0000", {busy, done, bus.dump_valid, bus.rf_we});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, bus.dump_valid, bus.rf_we} !== 3'b0) begin
      n_fail++; $display("FAIL rst_dump_next: got %b want 000", {busy, bus.dump_valid, bus.rf_we});
    end
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (done || bus.dump_valid || busy) n_done++;
    end
    n_tests++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL rst_dump_quiet: got %0d active cycles want 0", n_done);
    end
  endtask

  task automatic test_load_reset;
    int n_we;
    preload(16'h5000, 16'd4);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; bus.load_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0; mode = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = 16'hC000 + DATA_W'(c - 1);
      #1;
      n_tests++;
      if (bus.rf_we !== 1'b1 || bus.rf_wa3 !== ADDR_W'(c - 1)) begin
        n_fail++; $display("FAIL rst_load_wr: got we=%b wa=%h want 1 %h", bus.rf_we, bus.rf_wa3, c - 1);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    bus.load_data = 16'hC004;
    n_we = 0;
    #1;
    if (bus.rf_we) n_we++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, bus.load_ready} !== 2'b0) begin
      n_fail++; $display("FAIL rst_load_state: got busy=%b ready=%b want 0 0", busy, bus.load_ready);
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.rf_we) n_we++;
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (n_we != 0) begin
      n_fail++; $display("FAIL rst_load_we: got %0d writes after reset want 0", n_we);
    end
    bus.load_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rf_mem[0] !== 16'hC000 || rf_mem[1] !== 16'hC001 || rf_mem[2] !== 16'hC002 ||
        rf_mem[3] !== 16'hC003) begin
      n_fail++;
      $display("FAIL rst_load_mem: got %h %h %h %h want c000 c001 c002 c003",
               rf_mem[0], rf_mem[1], rf_mem[2], rf_mem[3]);
    end
    n_tests++;
    if (rf_mem[4] !== 16'h5004 || rf_mem[15] !== 16'd4) begin
      n_fail++; $display("FAIL rst_load_untouched: got R4=%h R15=%h want 5004 0004", rf_mem[4], rf_mem[15]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    pl_en = 1'b0; pl_base = '0; pl_pc = '0;
    bus.dump_ready = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    test_reset();
    test_dump_full();
    test_backpressure();
    test_load_full();
    test_load_gaps();
    test_dump_reset();
    test_load_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
